// File: rtl/wb_trace.sv
`default_nettype none
// ============================================================================
//  Module      : wb_trace
//  Description : Register-file write-back tracer. Captures CPU register
//                writes (PC, register number, data) into a show-ahead FIFO
//                with valid/ready drain. Events arriving while the FIFO is
//                full are dropped, counted and flagged with a sticky bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_trace #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     RegWrite,
    input  logic [4:0]               write_address,
    input  logic [31:0]              write_data,
    input  logic [31:0]              PC_out,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [4:0]               trace_addr,
    output logic [31:0]              trace_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         dropped
);

    // Pointer width; count needs one extra bit to represent "full".
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_ENT_W = 32 + 5 + 32;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]   c_DROP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   c_DROP_MAX = {CNT_W{1'b1}};

    // Entry storage: {pc, addr, data}. Deliberately not reset; the output
    // mask below hides stale contents whenever the FIFO is empty.
    logic [c_ENT_W-1:0] r_mem [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_dropped;

    logic               w_capture;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_ENT_W-1:0] w_head;

    // Event qualification and push/pop/drop decisions for this cycle.
    always_comb begin
        w_capture = enable & RegWrite & (write_address != 5'd0);
        w_empty   = (r_count == '0);
        w_full    = (r_count == c_CNT_FULL);
        // A pop is only honoured when an entry actually exists.
        w_pop     = trace_ready & ~w_empty;
        // When full, a same-cycle pop frees the slot the push will use.
        w_push    = w_capture & (~w_full | w_pop);
        w_drop    = w_capture & w_full & ~w_pop;
    end

    // Entry write; gated by reset so a reset edge never commits a push.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= {PC_out, write_address, write_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropped != c_DROP_MAX) begin
                r_dropped <= r_dropped + c_DROP_ONE;
            end
        end
    end

    // Show-ahead head presentation, masked to zero when empty.
    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        trace_valid = ~w_empty;
        trace_pc    = w_empty ? 32'd0 : w_head[c_ENT_W-1 -: 32];
        trace_addr  = w_empty ? 5'd0  : w_head[36:32];
        trace_data  = w_empty ? 32'd0 : w_head[31:0];
        count       = r_count;
        overflow    = r_overflow;
        dropped     = r_dropped;
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_trace.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_trace
//  Description : Directed self-checking bench for wb_trace (DEPTH=8, CNT_W=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_trace;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [31:0] PC_out;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] dropped;

    int checks;
    int errors;

    wb_trace #(.DEPTH(8), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .RegWrite      (RegWrite),
        .write_address (write_address),
        .write_data    (write_data),
        .PC_out        (PC_out),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_pc      (trace_pc),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .count         (count),
        .overflow      (overflow),
        .dropped       (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a capture event on the inputs (takes effect at the next edge).
    task automatic set_event(input logic [31:0] d);
        RegWrite      = 1'b1;
        write_address = 5'd7;
        write_data    = d;
        PC_out        = 32'h1000 + (d << 2);
    endtask

    task automatic clr_event();
        RegWrite      = 1'b0;
        write_address = 5'd0;
        write_data    = 32'd0;
        PC_out        = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", trace_valid); end
        checks++; if ({trace_pc, trace_addr, trace_data} !== 69'd0) begin errors++; $display("FAIL reset_fields got %0h/%0h/%0h exp 0", trace_pc, trace_addr, trace_data); end
        checks++; if (overflow !== 1'b0 || dropped !== 16'd0) begin errors++; $display("FAIL reset_drop got ovf=%0b drop=%0d exp 0/0", overflow, dropped); end
    endtask

    task automatic test_single();
        RegWrite = 1'b1; write_address = 5'd16; write_data = 32'h5; PC_out = 32'h4;
        trace_ready = 1'b0;
        step();
        clr_event();
        for (int k = 0; k < 4; k++) begin
            checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %0b exp 1", k, trace_valid); end
            checks++; if (trace_addr !== 5'd16 || trace_data !== 32'h5 || trace_pc !== 32'h4) begin
                errors++; $display("FAIL single_fields[%0d] got pc=%0h addr=%0d data=%0h exp 4/16/5", k, trace_pc, trace_addr, trace_data); end
            checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count[%0d] got %0d exp 1", k, count); end
            step();
        end
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        checks++; if (count !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("FAIL single_drain got cnt=%0d v=%0b exp 0/0", count, trace_valid); end
        checks++; if ({trace_pc, trace_addr, trace_data} !== 69'd0) begin errors++; $display("FAIL empty_mask got %0h/%0h/%0h exp 0", trace_pc, trace_addr, trace_data); end
        // Pop request while empty must change nothing.
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        checks++; if (count !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("FAIL empty_pop got cnt=%0d v=%0b exp 0/0", count, trace_valid); end
    endtask

    task automatic test_filter();
        RegWrite = 1'b1; write_address = 5'd0; write_data = 32'h33; PC_out = 32'h8;
        step();
        checks++; if (count !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("FAIL filter_zero got cnt=%0d v=%0b exp 0/0", count, trace_valid); end
        enable = 1'b0; write_address = 5'd8;
        step();
        checks++; if (count !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("FAIL filter_enable got cnt=%0d v=%0b exp 0/0", count, trace_valid); end
        enable = 1'b1;
        clr_event();
    endtask

    task automatic test_fill_overflow();
        trace_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            set_event(i);
            step();
        end
        clr_event();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %0b exp 1", overflow); end
        checks++; if (dropped !== 16'd2) begin errors++; $display("FAIL fill_dropped got %0d exp 2", dropped); end
        trace_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (trace_valid !== 1'b1 || trace_data !== 32'(i) || trace_pc !== 32'h1000 + 32'(i * 4) || trace_addr !== 5'd7) begin
                errors++; $display("FAIL drain_entry[%0d] got v=%0b data=%0h pc=%0h addr=%0d exp 1/%0h/%0h/7", i, trace_valid, trace_data, trace_pc, trace_addr, i, 32'h1000 + 32'(i * 4)); end
            step();
        end
        trace_ready = 1'b0;
        checks++; if (trace_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL drain_empty got v=%0b cnt=%0d exp 0/0", trace_valid, count); end
        checks++; if (overflow !== 1'b1 || dropped !== 16'd2) begin errors++; $display("FAIL drain_sticky got ovf=%0b drop=%0d exp 1/2", overflow, dropped); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp_d;
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_event(32'h10 + 32'(i));
            step();
        end
        checks++; if (count !== 4'd8 || trace_data !== 32'h10) begin errors++; $display("FAIL full_pre got cnt=%0d head=%0h exp 8/10", count, trace_data); end
        set_event(32'hAA);
        trace_ready = 1'b1;
        step();
        clr_event();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpp_count got %0d exp 8", count); end
        checks++; if (dropped !== 16'd2) begin errors++; $display("FAIL fullpp_dropped got %0d exp 2", dropped); end
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? 32'h11 + 32'(i) : 32'hAA;
            checks++; if (trace_valid !== 1'b1 || trace_data !== exp_d) begin
                errors++; $display("FAIL fullpp_entry[%0d] got v=%0b data=%0h exp 1/%0h", i, trace_valid, trace_data, exp_d); end
            step();
        end
        trace_ready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL fullpp_empty got %0d exp 0", count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_event(i);
            step();
            checks++; if (trace_valid !== 1'b1 || trace_data !== 32'(i)) begin
                errors++; $display("FAIL stream_head[%0d] got v=%0b data=%0h exp 1/%0h", i, trace_valid, trace_data, i); end
            checks++; if (count !== 4'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
        end
        clr_event();
        step();
        trace_ready = 1'b0;
        checks++; if (count !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("FAIL stream_end got cnt=%0d v=%0b exp 0/0", count, trace_valid); end
        checks++; if (dropped !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL stream_drop got drop=%0d ovf=%0b exp 0/0", dropped, overflow); end
    endtask

    task automatic test_reset_mid();
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_event(32'h40 + 32'(i));
            step();
        end
        clr_event();
        trace_ready = 1'b1;
        repeat (3) step();
        trace_ready = 1'b0;
        checks++; if (count !== 4'd5 || overflow !== 1'b1 || dropped !== 16'd1) begin
            errors++; $display("FAIL mid_pre got cnt=%0d ovf=%0b drop=%0d exp 5/1/1", count, overflow, dropped); end
        checks++; if (trace_data !== 32'h43) begin errors++; $display("FAIL mid_head got %0h exp 43", trace_data); end
        reset = 1'b1;
        set_event(32'h99);
        trace_ready = 1'b1;
        step();
        reset = 1'b0;
        trace_ready = 1'b0;
        clr_event();
        checks++; if (count !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got cnt=%0d v=%0b exp 0/0", count, trace_valid); end
        checks++; if (overflow !== 1'b0 || dropped !== 16'd0) begin errors++; $display("FAIL mid_reset_drop got ovf=%0b drop=%0d exp 0/0", overflow, dropped); end
        set_event(32'h77);
        #1;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL mid_bypass got v=%0b exp 0", trace_valid); end
        step();
        clr_event();
        checks++; if (trace_valid !== 1'b1 || trace_data !== 32'h77 || count !== 4'd1) begin
            errors++; $display("FAIL mid_next got v=%0b data=%0h cnt=%0d exp 1/77/1", trace_valid, trace_data, count); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        enable        = 1'b1;
        trace_ready   = 1'b0;
        RegWrite      = 1'b0;
        write_address = 5'd0;
        write_data    = 32'd0;
        PC_out        = 32'd0;
        #2;
        test_reset();
        test_single();
        test_filter();
        test_fill_overflow();
        test_push_pop_full();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
